// File: rtl/sonar_echo_detector_pkg.sv
// Shared definitions for the sonar echo detector: FSM state encoding and default widths.
package sonar_echo_detector_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_LISTEN = 2'd2,
    S_DONE   = 2'd3
  } sonar_state_e;

  localparam int unsigned DEF_N_CH     = 2;
  localparam int unsigned DEF_DW       = 16;
  localparam int unsigned DEF_MAF_LOG2 = 4;
  localparam int unsigned DEF_TOF_W    = 16;

endpackage

// File: rtl/sonar_echo_detector_env_maf.sv
// Per-channel envelope: saturating |x| followed by a 2**MAF_LOG2-sample boxcar average.
module sonar_env_maf #(
  parameter int unsigned DW       = 16,
  parameter int unsigned MAF_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pcm_valid,
  input  logic [DW-1:0] pcm_data,
  output logic [DW-1:0] env
);

  localparam int unsigned WIN   = 1 << MAF_LOG2;
  localparam int unsigned ENV_W = DW + MAF_LOG2;
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

  logic [DW-1:0]    abs_new;
  logic [DW-1:0]    hist [WIN];
  logic [ENV_W-1:0] sum;

  always_comb begin
    abs_new = pcm_data;
    if (pcm_data == MIN_NEG)
      abs_new = MAX_POS;
    else if (pcm_data[DW-1])
      abs_new = -pcm_data;
  end

  // Running sum: add newest, drop the sample falling out of the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      for (int unsigned i = 0; i < WIN; i++) hist[i] <= '0;
    end else if (pcm_valid) begin
      sum     <= sum + ENV_W'(abs_new) - ENV_W'(hist[WIN-1]);
      hist[0] <= abs_new;
      for (int unsigned i = 1; i < WIN; i++) hist[i] <= hist[i-1];
    end
  end

  assign env = sum[ENV_W-1:MAF_LOG2];

endmodule

// File: rtl/sonar_echo_detector.sv
// Multi-channel time-of-flight echo detector: envelope, hysteresis arm/capture, ping FSM, sticky IRQ.
module sonar_echo_detector
  import sonar_echo_detector_pkg::*;
#(
  parameter int unsigned N_CH     = DEF_N_CH,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAF_LOG2 = DEF_MAF_LOG2,
  parameter int unsigned TOF_W    = DEF_TOF_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pcm_valid,
  input  logic [N_CH*DW-1:0]    pcm_data,
  input  logic                  ping_start,
  input  logic [DW-1:0]         thr_hi,
  input  logic [DW-1:0]         thr_lo,
  input  logic [TOF_W-1:0]      blank_len,
  input  logic [TOF_W-1:0]      timeout,
  input  logic                  irq_clr,
  output logic [N_CH*DW-1:0]    env_o,
  output logic [N_CH*TOF_W-1:0] tof_o,
  output logic [N_CH-1:0]       tof_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  irq_o
);

  sonar_state_e      state, state_nxt;
  logic [DW-1:0]     env [N_CH];
  logic [TOF_W-1:0]  sample_idx;
  logic              env_upd;
  logic [N_CH-1:0]   armed;
  logic [N_CH-1:0]   hit;
  logic              all_cap;
  logic              listen_entry;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    sonar_env_maf #(
      .DW       (DW),
      .MAF_LOG2 (MAF_LOG2)
    ) u_maf (
      .clk       (clk),
      .rst_n     (rst_n),
      .pcm_valid (pcm_valid),
      .pcm_data  (pcm_data[ch*DW +: DW]),
      .env       (env[ch])
    );
    assign env_o[ch*DW +: DW] = env[ch];
  end

  // Detection runs on the cycle after pcm_valid, when env and sample_idx both reflect that sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) env_upd <= 1'b0;
    else        env_upd <= pcm_valid;
  end

  always_comb begin
    hit = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++)
      hit[ch] = (state == S_LISTEN) && env_upd && armed[ch] && !tof_valid_o[ch] && (env[ch] >= thr_hi);
    all_cap = &(tof_valid_o | hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ping_start) state_nxt = S_BLANK;
      S_BLANK:  begin
        if (ping_start)                    state_nxt = S_BLANK;
        else if (sample_idx >= blank_len)  state_nxt = S_LISTEN;
      end
      S_LISTEN: begin
        if (ping_start)                                        state_nxt = S_BLANK;
        else if (env_upd && (all_cap || sample_idx == timeout)) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = ping_start ? S_BLANK : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign listen_entry = (state == S_BLANK) && (state_nxt == S_LISTEN);
  assign busy_o       = (state == S_BLANK) || (state == S_LISTEN);
  assign done_o       = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sample_idx <= '0;
    else if (ping_start)
      sample_idx <= '0;
    else if (pcm_valid && busy_o && sample_idx < timeout)
      sample_idx <= sample_idx + TOF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tof_o       <= '0;
      tof_valid_o <= '0;
    end else if (ping_start) begin
      tof_o       <= '0;
      tof_valid_o <= '0;
    end else begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        if (hit[ch]) begin
          tof_o[ch*TOF_W +: TOF_W] <= sample_idx;
          tof_valid_o[ch]          <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      armed <= '0;
    else if (listen_entry)
      armed <= '0;
    else if (state == S_LISTEN && env_upd) begin
      for (int unsigned ch = 0; ch < N_CH; ch++)
        if (env[ch] < thr_lo) armed[ch] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                irq_o <= 1'b0;
    else if (state == S_DONE)  irq_o <= 1'b1;
    else if (irq_clr)          irq_o <= 1'b0;
  end

endmodule

// File: tb/tb_sonar_echo_detector.sv
// Directed self-checking bench for sonar_echo_detector (N_CH=2, DW=16, MAF_LOG2=4, TOF_W=16).
module tb_sonar_echo_detector;

  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcm_valid = 1'b0;
  logic [31:0] pcm_data = '0;
  logic        ping_start = 1'b0;
  logic [15:0] thr_hi = 16'd1000;
  logic [15:0] thr_lo = 16'd200;
  logic [15:0] blank_len = 16'd10;
  logic [15:0] timeout = 16'd500;
  logic        irq_clr = 1'b0;
  logic [31:0] env_o;
  logic [31:0] tof_o;
  logic [1:0]  tof_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        irq_o;

  int n_tests = 0;
  int n_fail = 0;
  int tb_idx = 0;
  int done_cnt = 0;
  int done_at = -1;
  int dc0;

  sonar_echo_detector #(
    .N_CH     (2),
    .DW       (16),
    .MAF_LOG2 (4),
    .TOF_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcm_valid   (pcm_valid),
    .pcm_data    (pcm_data),
    .ping_start  (ping_start),
    .thr_hi      (thr_hi),
    .thr_lo      (thr_lo),
    .blank_len   (blank_len),
    .timeout     (timeout),
    .irq_clr     (irq_clr),
    .env_o       (env_o),
    .tof_o       (tof_o),
    .tof_valid_o (tof_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      done_at = tb_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d0, input logic [15:0] d1);
    pcm_data  = {d1, d0};
    pcm_valid = 1'b1;
    tb_idx++;
    tick();
    pcm_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic ping();
    ping_start = 1'b1;
    tb_idx = 0;
    tick();
    ping_start = 1'b0;
  endtask

  task automatic flush(input logic [15:0] d0, input logic [15:0] d1);
    for (int i = 0; i < 16; i++) send(d0, d1);
  endtask

  // Step each channel from 0 to 4000 at the given sample index (relative to last ping)
  task automatic run_to(input int last, input int s0, input int s1);
    while (tb_idx < last)
      send((tb_idx + 1 >= s0) ? 16'd4000 : 16'd0, (tb_idx + 1 >= s1) ? 16'd4000 : 16'd0);
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++;
    if ({env_o, tof_o, tof_valid_o, busy_o, done_o, irq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs=%h expected 0", {env_o, tof_o, tof_valid_o, busy_o, done_o, irq_o});
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    blank_len = 16'd10; timeout = 16'd500;
    ping();
    for (int i = 0; i < 20; i++) send(16'd3000, 16'd100);
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_listen: got %b expected 1", busy_o); end
    dc0 = done_cnt;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({env_o, tof_o, tof_valid_o, busy_o, done_o, irq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs=%h expected 0", {env_o, tof_o, tof_valid_o, busy_o, done_o, irq_o});
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_tests++;
    if (done_cnt !== dc0) begin n_fail++; $display("FAIL reset_no_done: done pulses %0d expected %0d", done_cnt, dc0); end
    ping();
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ping_after_reset: busy %b expected 1", busy_o); end
  endtask

  task automatic test_single_echo();
    flush(16'd0, 16'd0);
    timeout = 16'd500;
    ping();
    dc0 = done_cnt;
    run_to(500, 100, NEVER);
    tick();
    n_tests++;
    if (tof_o[15:0] !== 16'd103) begin n_fail++; $display("FAIL single_tof0: got %0d expected 103", tof_o[15:0]); end
    n_tests++;
    if (tof_valid_o !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b expected 01", tof_valid_o); end
    n_tests++;
    if (done_cnt !== dc0 + 1 || done_at !== 500) begin
      n_fail++; $display("FAIL single_done: pulses %0d at sample %0d expected %0d at 500", done_cnt - dc0, done_at, 1);
    end
    n_tests++;
    if (irq_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_irq_busy: irq %b busy %b expected 1 0", irq_o, busy_o); end
  endtask

  task automatic test_both_channels();
    flush(16'd0, 16'd0);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    n_tests++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b expected 0", irq_o); end
    ping();
    dc0 = done_cnt;
    run_to(190, 120, 180);
    n_tests++;
    if (tof_o !== {16'd183, 16'd123} || tof_valid_o !== 2'b11) begin
      n_fail++; $display("FAIL both_tof: got %0d/%0d valid %b expected 123/183 valid 11", tof_o[15:0], tof_o[31:16], tof_valid_o);
    end
    n_tests++;
    if (done_cnt !== dc0 + 1 || done_at !== 183) begin
      n_fail++; $display("FAIL both_done: pulses %0d at sample %0d expected 1 at 183", done_cnt - dc0, done_at);
    end
    n_tests++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL both_irq: got %b expected 1", irq_o); end
  endtask

  task automatic test_ringing();
    flush(16'd3000, 16'd0);
    timeout = 16'd250;
    ping();
    dc0 = done_cnt;
    while (tb_idx < 54) send((tb_idx + 1 <= 40) ? 16'd3000 : 16'd0, 16'd0);
    n_tests++;
    if (tof_valid_o !== 2'b00) begin n_fail++; $display("FAIL ring_no_early: valid %b expected 00", tof_valid_o); end
    while (tb_idx < 250) send((tb_idx + 1 >= 200) ? 16'd4000 : 16'd0, 16'd0);
    tick();
    n_tests++;
    if (tof_o[15:0] !== 16'd203 || tof_valid_o !== 2'b01) begin
      n_fail++; $display("FAIL ring_tof: got %0d valid %b expected 203 valid 01", tof_o[15:0], tof_valid_o);
    end
    n_tests++;
    if (done_cnt !== dc0 + 1 || done_at !== 250) begin
      n_fail++; $display("FAIL ring_done: pulses %0d at sample %0d expected 1 at 250", done_cnt - dc0, done_at);
    end
  endtask

  task automatic test_saturation();
    flush(16'h8000, 16'hFFFB);
    n_tests++;
    if (env_o !== {16'd5, 16'd32767}) begin
      n_fail++; $display("FAIL sat_env: got %0d/%0d expected 32767/5", env_o[15:0], env_o[31:16]);
    end
    pcm_data = '0; pcm_valid = 1'b1;
    #1;
    n_tests++;
    if (env_o !== {16'd5, 16'd32767}) begin
      n_fail++; $display("FAIL env_latency: got %0d/%0d expected 32767/5 before edge", env_o[15:0], env_o[31:16]);
    end
    tick(); pcm_valid = 1'b0; tick(); tick();
    n_tests++;
    if (env_o !== {16'd4, 16'd30719}) begin
      n_fail++; $display("FAIL env_drop: got %0d/%0d expected 30719/4", env_o[15:0], env_o[31:16]);
    end
  endtask

  task automatic test_restart();
    flush(16'd0, 16'd0);
    timeout = 16'd500;
    ping();
    dc0 = done_cnt;
    run_to(50, 20, NEVER);
    n_tests++;
    if (tof_o[15:0] !== 16'd23 || tof_valid_o !== 2'b01) begin
      n_fail++; $display("FAIL pre_restart_tof: got %0d valid %b expected 23 valid 01", tof_o[15:0], tof_valid_o);
    end
    ping();
    n_tests++;
    if (tof_o !== '0 || tof_valid_o !== 2'b00 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear: tof %h valid %b busy %b expected 0 00 1", tof_o, tof_valid_o, busy_o);
    end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    run_to(42, 30, 40);
    n_tests++;
    if (done_cnt !== dc0) begin n_fail++; $display("FAIL restart_no_done: pulses %0d expected 0", done_cnt - dc0); end
    n_tests++;
    if (tof_o[15:0] !== 16'd33 || tof_valid_o !== 2'b01 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL restart_idx: tof0 %0d valid %b irq %b expected 33 01 0", tof_o[15:0], tof_valid_o, irq_o);
    end
    pcm_data = {16'd4000, 16'd4000}; pcm_valid = 1'b1; tb_idx++;
    tick(); pcm_valid = 1'b0;
    tick();
    irq_clr = 1'b1;
    n_tests++;
    if (done_o !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1", done_o); end
    tick(); irq_clr = 1'b0;
    n_tests++;
    if (irq_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_set_wins: irq %b done %b expected 1 0", irq_o, done_o);
    end
    n_tests++;
    if (tof_o !== {16'd43, 16'd33} || done_cnt !== dc0 + 1) begin
      n_fail++; $display("FAIL restart_final: tof %0d/%0d pulses %0d expected 33/43 1", tof_o[15:0], tof_o[31:16], done_cnt - dc0);
    end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_both_channels();
    test_ringing();
    test_saturation();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
